// File: rtl/console_pkg.sv
// Shared constants, character codes and state encoding for the VGA console writer.
package console_pkg;

    localparam int COLS      = 70;
    localparam int RING_ROWS = 64;
    localparam int VIS_ROWS  = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PUT,
        ST_CLEAR,
        ST_TAB
    } console_state_t;

    function automatic logic isPrintable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/console_addr_gen.sv
// Registered VRAM byte address generator: o_addr <= row*COLS + col on each enabled cycle.
module console_addr_gen
    import console_pkg::*;
#(
    parameter int COLS = console_pkg::COLS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [5:0]  i_row,
    input  logic [6:0]  i_col,
    output logic [12:0] o_addr
);

    logic [12:0] w_row;
    logic [12:0] w_rowBase;
    logic [12:0] w_addr;
    logic [12:0] r_addr;

    assign w_row = {7'b0, i_row};

    // 70 = 64 + 4 + 2, so the row base needs only three shifted adds.
    generate
        if (COLS == 70) begin : g_shiftAdd
            assign w_rowBase = (w_row << 6) + (w_row << 2) + (w_row << 1);
        end else begin : g_mult
            assign w_rowBase = 13'(w_row * COLS);
        end
    endgenerate

    assign w_addr = w_rowBase + {6'b0, i_col};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= 13'd0;
        end else if (i_en) begin
            r_addr <= w_addr;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/vga_console_writer.sv
// Character-stream writer for the text-mode VGA ring VRAM (cursor, wrap, backspace, scroll).
// Optional feature: define CONSOLE_TAB_EN to expand 0x09 to spaces up to the next multiple of 8.
module vga_console_writer
    import console_pkg::*;
#(
    parameter int COLS      = console_pkg::COLS,
    parameter int RING_ROWS = console_pkg::RING_ROWS,
    parameter int VIS_ROWS  = console_pkg::VIS_ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        wren,
    output logic [31:0] wraddr,
    output logic [31:0] datain,
    output logic [2:0]  memop,
    output logic [5:0]  start_line,
    output logic [5:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_VIS = 6'(VIS_ROWS - 1);
    localparam logic [5:0] LAST_ROW = 6'(RING_ROWS - 1);
    localparam logic [5:0] ROW_MASK = 6'(RING_ROWS - 1);

    console_state_t r_state;
    console_state_t w_stateNext;

    logic [5:0]  r_curRow;
    logic [5:0]  w_curRowNext;
    logic [6:0]  r_curCol;
    logic [6:0]  w_curColNext;
    logic [5:0]  r_visRow;
    logic [5:0]  w_visRowNext;
    logic [5:0]  r_startLine;
    logic [5:0]  w_startLineNext;
    logic [6:0]  r_clrCol;
    logic [6:0]  w_clrColNext;
    logic [5:0]  r_initRow;
    logic [5:0]  w_initRowNext;
    logic        r_initDone;
    logic        w_initDoneNext;
    logic        r_advance;
    logic        w_advanceNext;
    logic        r_wren;
    logic        w_wrenNext;
    logic [7:0]  r_data;
    logic [7:0]  w_dataNext;
    logic        r_charReady;
    logic        r_busy;

    logic [5:0]  w_wrRow;
    logic [6:0]  w_wrCol;
    logic [12:0] w_addr;
    logic        w_accept;
    logic        w_newline;
    logic [5:0]  w_rowInc;
    logic [6:0]  w_colInc;

    assign w_accept = char_valid && r_charReady;
    assign w_rowInc = (r_curRow + 6'd1) & ROW_MASK;
    assign w_colInc = r_curCol + 7'd1;

    // Every write is decided one edge ahead: the row/col chosen here become wraddr
    // in the same cycle that wren goes high, so the strobe and address stay aligned.
    always_comb begin
        w_stateNext     = r_state;
        w_curRowNext    = r_curRow;
        w_curColNext    = r_curCol;
        w_visRowNext    = r_visRow;
        w_startLineNext = r_startLine;
        w_clrColNext    = r_clrCol;
        w_initRowNext   = r_initRow;
        w_initDoneNext  = r_initDone;
        w_advanceNext   = r_advance;
        w_wrenNext      = 1'b0;
        w_dataNext      = r_data;
        w_wrRow         = r_curRow;
        w_wrCol         = r_curCol;
        w_newline       = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (r_initDone) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_wrenNext = 1'b1;
                    w_dataNext = CH_SPACE;
                    w_wrRow    = r_initRow;
                    w_wrCol    = r_clrCol;
                    if (r_clrCol == LAST_COL) begin
                        w_clrColNext = 7'd0;
                        if (r_initRow == LAST_ROW) begin
                            w_initDoneNext = 1'b1;
                        end else begin
                            w_initRowNext = r_initRow + 6'd1;
                        end
                    end else begin
                        w_clrColNext = r_clrCol + 7'd1;
                    end
                end
            end

            ST_IDLE: begin
                if (w_accept) begin
                    if (isPrintable(char_data)) begin
                        w_stateNext   = ST_PUT;
                        w_wrenNext    = 1'b1;
                        w_dataNext    = char_data;
                        w_advanceNext = 1'b1;
                    end else if (char_data == CH_LF) begin
                        w_newline = 1'b1;
                    end else if (char_data == CH_CR) begin
                        w_curColNext = 7'd0;
                    end else if ((char_data == CH_BS) && (r_curCol != 7'd0)) begin
                        w_stateNext   = ST_PUT;
                        w_curColNext  = r_curCol - 7'd1;
                        w_wrCol       = r_curCol - 7'd1;
                        w_wrenNext    = 1'b1;
                        w_dataNext    = CH_SPACE;
                        w_advanceNext = 1'b0;
`ifdef CONSOLE_TAB_EN
                    end else if (char_data == CH_TAB) begin
                        w_stateNext = ST_TAB;
                        w_wrenNext  = 1'b1;
                        w_dataNext  = CH_SPACE;
`endif
                    end
                end
            end

            ST_PUT: begin
                if (r_advance && (r_curCol == LAST_COL)) begin
                    w_newline = 1'b1;
                end else begin
                    if (r_advance) begin
                        w_curColNext = w_colInc;
                    end
                    w_stateNext = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                if (r_clrCol == LAST_COL) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_clrColNext = r_clrCol + 7'd1;
                    w_wrenNext   = 1'b1;
                    w_dataNext   = CH_SPACE;
                    w_wrCol      = r_clrCol + 7'd1;
                end
            end

`ifdef CONSOLE_TAB_EN
            ST_TAB: begin
                if (r_curCol == LAST_COL) begin
                    w_newline = 1'b1;
                end else begin
                    w_curColNext = w_colInc;
                    if (w_colInc[2:0] == 3'd0) begin
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_wrenNext = 1'b1;
                        w_dataNext = CH_SPACE;
                        w_wrCol    = w_colInc;
                    end
                end
            end
`endif

            default: begin
                w_stateNext = ST_INIT;
            end
        endcase

        // Shared newline path: move the cursor, scroll once the screen is full,
        // and issue column 0 of the new row so CLEAR follows without a gap.
        if (w_newline) begin
            w_curColNext = 7'd0;
            w_curRowNext = w_rowInc;
            if (r_visRow == LAST_VIS) begin
                w_startLineNext = r_startLine + 6'd1;
            end else begin
                w_visRowNext = r_visRow + 6'd1;
            end
            w_stateNext  = ST_CLEAR;
            w_clrColNext = 7'd0;
            w_wrenNext   = 1'b1;
            w_dataNext   = CH_SPACE;
            w_wrRow      = w_rowInc;
            w_wrCol      = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_curRow    <= 6'd0;
            r_curCol    <= 7'd0;
            r_visRow    <= 6'd0;
            r_startLine <= 6'd0;
            r_clrCol    <= 7'd0;
            r_initRow   <= 6'd0;
            r_initDone  <= 1'b0;
            r_advance   <= 1'b0;
            r_wren      <= 1'b0;
            r_data      <= 8'd0;
            r_charReady <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_stateNext;
            r_curRow    <= w_curRowNext;
            r_curCol    <= w_curColNext;
            r_visRow    <= w_visRowNext;
            r_startLine <= w_startLineNext;
            r_clrCol    <= w_clrColNext;
            r_initRow   <= w_initRowNext;
            r_initDone  <= w_initDoneNext;
            r_advance   <= w_advanceNext;
            r_wren      <= w_wrenNext;
            r_data      <= w_dataNext;
            r_charReady <= (w_stateNext == ST_IDLE);
            r_busy      <= (w_stateNext != ST_IDLE);
        end
    end

    console_addr_gen #(
        .COLS (COLS)
    ) u_addrGen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_wrenNext),
        .i_row  (w_wrRow),
        .i_col  (w_wrCol),
        .o_addr (w_addr)
    );

    assign char_ready = r_charReady;
    assign wren       = r_wren;
    assign wraddr     = {19'b0, w_addr};
    assign datain     = {24'h0, r_data};
    assign memop      = 3'b000;
    assign start_line = r_startLine;
    assign cur_row    = r_curRow;
    assign cur_col    = r_curCol;
    assign busy       = r_busy;

endmodule
